// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding
// and the fixed-priority (lowest index wins) encoder.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam int MAX_IRQ = 32;

  // Returns the lowest set index of vec; 0 when vec is empty (callers gate with |vec).
  function automatic logic [4:0] prio_enc(input logic [MAX_IRQ-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line multi-flop synchroniser with registered rising-edge detect.
module irq_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] sync_sr;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr <= '0;
      prev    <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], async_in};
      prev    <= sync_sr[STAGES-1];
    end
  end

  assign sync_out = sync_sr[STAGES-1];
  assign rise     = sync_out & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// NUM_IRQ-line interrupt controller: sync, pending latch, mask, fixed priority,
// request/ack/reti handshake. Optional level-trigger mode: IRQ_LEVEL_TRIG_EN.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 3,
  parameter int ID_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
`ifdef IRQ_LEVEL_TRIG_EN
  input  logic                trig_we,
  input  logic [NUM_IRQ-1:0]  trig_d,
`endif
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_d,
  input  logic                irq_ack,
  input  logic                reti,
  output logic                irq_req,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic                in_service,
  output logic [ID_WIDTH-1:0] in_service_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  mask
);

  localparam int ID_W_MIN = $clog2(NUM_IRQ);

  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ || ID_WIDTH < ID_W_MIN || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("interrupt_controller: illegal NUM_IRQ/ID_WIDTH/SYNC_STAGES combination");
  end

  // Handshake: irq_req is held with a frozen irq_id until a one-cycle irq_ack;
  // in_service is held until a one-cycle reti. Pulses in other states are ignored.

  logic [NUM_IRQ-1:0] sync_lvl;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] level_mode;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] pending_d;
  logic [MAX_IRQ-1:0] req_vec;
  logic [4:0]         winner;
  logic               req_any;
  irq_state_e         state_q, state_d;
  logic               load_id;
  logic               take_ack;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (reset),
      .async_in (irq_in[i]),
      .sync_out (sync_lvl[i]),
      .rise     (rise[i])
    );
  end

`ifdef IRQ_LEVEL_TRIG_EN
  logic [NUM_IRQ-1:0] trig_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        trig_level <= '0;
    else if (trig_we) trig_level <= trig_d;
  end

  assign level_mode = trig_level;
`else
  assign level_mode = '0;
`endif

  assign req_vec = MAX_IRQ'(pending & mask);
  assign winner  = prio_enc(req_vec);
  assign req_any = |req_vec;
  assign ack_clr = take_ack ? (NUM_IRQ'(1) << irq_id) : '0;

  // A new edge in the same cycle as the ack clear wins, so that event survives.
  assign pending_d = (level_mode & sync_lvl) |
                     (~level_mode & ((pending & ~ack_clr) | rise));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= '1;
    end else begin
      pending <= pending_d;
      if (mask_we) mask <= mask_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_id  = 1'b0;
    take_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = REQUEST;
          load_id = 1'b1;
        end
      end
      REQUEST: begin
        if (irq_ack) begin
          state_d  = SERVICE;
          take_ack = 1'b1;
        end
      end
      SERVICE: begin
        if (reti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_id        <= '0;
      in_service_id <= '0;
    end else begin
      if (load_id)  irq_id        <= ID_WIDTH'(winner);
      if (take_ack) in_service_id <= irq_id;
    end
  end

  assign irq_req    = (state_q == REQUEST);
  assign in_service = (state_q == SERVICE);

endmodule
